alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares one combinational `alu` instance between two requesters, using a round-robin grant and valid/ready handshakes on both the request and response sides. The block latches the granted operands and opcode, then drives the ALU from those registers. It captures the result and the four flags (n, z, o, c) into a response register and holds them until the consumer accepts. It sits between the instruction-issue logic and the shared ALU datapath.

Parameters:
N, 4, operand/result width in bits; passed unchanged to the embedded `alu #(N)`.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 request accepted this cycle when high with req0_valid
req0_a  in  N  requester 0 operand a
req0_b  in  N  requester 0 operand b
req0_op  in  4  requester 0 ALU select
req1_valid  in  1  requester 1 has an operation pending
req1_ready  out  1  requester 1 request accepted this cycle when high with req1_valid
req1_a  in  N  requester 1 operand a
req1_b  in  N  requester 1 operand b
req1_op  in  4  requester 1 ALU select
rsp_valid  out  1  response register holds a valid result
rsp_ready  in  1  consumer accepts the response
rsp_id  out  1  index of the requester that owns the response
rsp_result  out  N  captured ALU out
rsp_flags  out  4  captured {fn, fz, fo, fc}

Behaviour:
- ALU select encoding, passed through unmodified:
  - 0000 add, 0001 sub, 0010 sla, 0011 sra, 0100 and, 0101 or, 0110 xor, 0111 sll, 1000 srl, 1001 not.
  - 1010–1111 give out = 0, so fz = 1; the block does not flag these as errors.
- ALU inputs come only from the internal registers op_a, op_b, op_sel, never directly from the request ports.
- States:
  - IDLE: no operation in flight.
  - EXEC: ALU evaluates the latched operands.
  - RESP: response held for the consumer.
- IDLE:
  - reqX_ready = 1 only for the requester selected by the arbiter; 0 for the other.
  - On handshake: latch a, b, op into op_a, op_b, op_sel; record owner id; update last_grant to the granted index; go to EXEC.
- EXEC: lasts exactly one cycle. At its end, capture ALU out and flags into rsp_result/rsp_flags, set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_flags hold stable until rsp_ready = 1.
  - On the handshake cycle: rsp_valid = 0 next cycle, go to IDLE.
- Both reqX_ready = 0 in EXEC and RESP, so there is no request buffering.
- Latency: request handshake at cycle T gives rsp_valid = 1 at T+2. Minimum issue interval is 3 cycles, with rsp_ready tied high.
- Arbitration, decided combinationally in IDLE:
  - Only one valid requester: it wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - A requester must hold its fields stable while reqX_valid = 1 and reqX_ready = 0.
- Reset (rst = 1 at a clock edge), from any state:
  - State = IDLE, last_grant = 1, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0, op registers = 0.
  - Any in-flight operation is discarded; no response is ever produced for it.
  - reqX_ready is 0 while rst = 1.
- No request is lost or duplicated: every request handshake yields exactly one response handshake unless reset intervenes.

Test Plan:
- Single add: req0 a=1001, b=1010, op=0000 at T, rsp_ready=1 → rsp_valid at T+2, rsp_id=0, rsp_result=0011, fc=1, fo=1, fz=0, fn=0.
- Tie arbitration:
  - Stimulus: req0 (sub 0111−0100) and req1 (xor 1010^0011) both held valid from reset.
  - Required: req0 granted first → 0011, id 0; then req1 → 1001, id 1.
  - Then re-raise both valid: req0 is granted.
- Backpressure:
  - Stimulus: req1 sra 1011 by 0001, rsp_ready=0 for 5 cycles.
  - Required: rsp_result=1101, rsp_id=1 held stable throughout; both reqX_ready=0; the response is consumed on the first rsp_ready=1 cycle; IDLE on the following cycle.
- Reset mid-operation: assert rst for one cycle while in EXEC (req0 and 1001,1010) → next cycle rsp_valid=0 and all outputs 0; no response appears afterwards; next request proceeds normally.
- Zero flag / unused select: req0 a=0000, b=1010, op=1111 → rsp_result=0000, fz=1; then req0 not 1010 → rsp_result=0101, fz=0.
- Lone requester: req1 alone, repeatedly valid with sll 0011 by 0001 → granted every issue slot (no starvation by round-robin), each rsp_result=0110, rsp_id=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Operands are registered, evaluated for one cycle, and the result held until accepted.
module alu #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic [N-1:0] out,
  output logic         fn,
  output logic         fz,
  output logic         fo,
  output logic         fc
);

  logic [N:0] sum;

  always_comb begin
    sum = '0;
    out = '0;
    fo  = 1'b0;
    fc  = 1'b0;
    case (sel)
      4'b0000: begin
        sum = {1'b0, a} + {1'b0, b};
        out = sum[N-1:0];
        fc  = sum[N];
        fo  = (a[N-1] == b[N-1]) && (out[N-1] != a[N-1]);
      end
      4'b0001: begin
        // carry out of a + ~b + 1, i.e. set when no borrow
        sum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        out = sum[N-1:0];
        fc  = sum[N];
        fo  = (a[N-1] != b[N-1]) && (out[N-1] != a[N-1]);
      end
      4'b0010: out = a << b;
      4'b0011: out = $signed(a) >>> b;
      4'b0100: out = a & b;
      4'b0101: out = a | b;
      4'b0110: out = a ^ b;
      4'b0111: out = a << b;
      4'b1000: out = a >> b;
      4'b1001: out = ~a;
      default: out = '0;
    endcase
    fn = out[N-1];
    fz = (out == '0);
  end

endmodule

module alu_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state;
  logic         last_grant;
  logic         owner;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [3:0]   op_sel;
  logic [N-1:0] alu_out;
  logic         fn, fz, fo, fc;
  logic         idle;
  logic         pick1;
  logic         hs0;
  logic         hs1;

  alu #(.N(N)) u_alu (
    .a  (op_a),
    .b  (op_b),
    .sel(op_sel),
    .out(alu_out),
    .fn (fn),
    .fz (fz),
    .fo (fo),
    .fc (fc)
  );

  // requester 1 wins if alone, or on a tie when 0 was served last
  assign idle       = (state == IDLE) && !rst;
  assign pick1      = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = idle && !pick1;
  assign req1_ready = idle && pick1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs1) begin
            op_a       <= req1_a;
            op_b       <= req1_b;
            op_sel     <= req1_op;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end else if (hs0) begin
            op_a       <= req0_a;
            op_b       <= req0_b;
            op_sel     <= req0_op;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_out;
          rsp_flags  <= {fn, fz, fo, fc};
          rsp_id     <= owner;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
